// File: rtl/dist_pkg.sv
// Shared types, widths and the saturation helper for the echo-to-distance converter.
package dist_pkg;

  localparam int CM_W  = 10;
  localparam int RAW_W = 22;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    POST,
    OUT
  } state_t;

  // Clamp a raw quotient to the saturation distance and narrow it to CM_W bits.
  function automatic logic [CM_W-1:0] sat_cm(input logic [RAW_W-1:0] q,
                                             input logic [RAW_W-1:0] max_cm);
    return (q > max_cm) ? max_cm[CM_W-1:0] : q[CM_W-1:0];
  endfunction

endpackage

// File: rtl/udiv_seq.sv
// Sequential restoring unsigned divider: one quotient bit per cycle, DW cycles after start.
// done is high during the cycle of the final step; quotient is valid from the next cycle.
module udiv_seq #(
  parameter int DW = 22,
  parameter int VW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quotient
);

  localparam int CW = $clog2(DW + 1);

  logic [CW-1:0] cnt;
  logic [VW-1:0] rem;
  logic [VW-1:0] dvs;
  logic [VW:0]   trial;
  logic [VW:0]   diff;

  // The dividend shifts out of the top of quotient while quotient bits shift in below.
  assign trial = {rem, quotient[DW-1]};
  assign diff  = trial - {1'b0, dvs};
  assign done  = (cnt == CW'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
    end else if (start) begin
      cnt      <= CW'(DW);
      rem      <= '0;
      dvs      <= divisor;
      quotient <= dividend;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (!diff[VW]) begin
        rem      <= diff[VW-1:0];
        quotient <= {quotient[DW-2:0], 1'b1};
      end else begin
        rem      <= trial[VW-1:0];
        quotient <= {quotient[DW-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/distance_converter.sv
// Converts an echo width in clk cycles to a filtered distance in cm with obstacle hysteresis.
// Optional build macro DIST_MEDIAN3_EN adds a 3-tap median filter ahead of the hysteresis.
module distance_converter
  import dist_pkg::*;
#(
  parameter int CYCLES_PER_CM = 2900,
  parameter int MAX_CM        = 400,
  parameter int NEAR_CM       = 15,
  parameter int FAR_CM        = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw_valid,
  input  logic [RAW_W-1:0] raw_count,
  output logic             busy,
  output logic             dist_valid,
  output logic [CM_W-1:0]  dist_cm,
  output logic             out_of_range,
  output logic             obstacle,
  output logic             overrun
);

  localparam int DIV_W = $clog2(CYCLES_PER_CM + 1);
  localparam logic [DIV_W-1:0] DIVISOR = DIV_W'(CYCLES_PER_CM);
  localparam logic [RAW_W-1:0] MAX_RAW = RAW_W'(MAX_CM);
  localparam logic [CM_W-1:0]  MAX_V   = CM_W'(MAX_CM);
  localparam logic [CM_W-1:0]  NEAR_V  = CM_W'(NEAR_CM);
  localparam logic [CM_W-1:0]  FAR_V   = CM_W'(FAR_CM);

  state_t           state_q;
  state_t           state_d;
  logic             start;
  logic             div_done;
  logic [RAW_W-1:0] quo;
  logic [CM_W-1:0]  sat;
  logic [CM_W-1:0]  filt;
  logic             obs_next;

  assign start      = (state_q == IDLE) && raw_valid;
  assign busy       = (state_q != IDLE);
  assign dist_valid = (state_q == OUT);
  assign overrun    = raw_valid && busy;

  // The divider holds the latched raw_count; raw_valid is only seen while IDLE.
  udiv_seq #(
    .DW(RAW_W),
    .VW(DIV_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (raw_count),
    .divisor  (DIVISOR),
    .done     (div_done),
    .quotient (quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (raw_valid) state_d = DIV;
      DIV:  if (div_done)  state_d = POST;
      POST: state_d = OUT;
      OUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DIST_MEDIAN3_EN
  logic [CM_W-1:0] h1;
  logic [CM_W-1:0] h2;
  logic [CM_W-1:0] lo;
  logic [CM_W-1:0] hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h1 <= MAX_V;
      h2 <= MAX_V;
    end else if (state_q == POST) begin
      h2 <= h1;
      h1 <= sat;
    end
  end
`endif

  always_comb begin
    sat = sat_cm(quo, MAX_RAW);
`ifdef DIST_MEDIAN3_EN
    lo   = (sat < h1) ? sat : h1;
    hi   = (sat < h1) ? h1  : sat;
    filt = (h2 < lo) ? lo : ((h2 > hi) ? hi : h2);
`else
    filt = sat;
`endif
    obs_next = obstacle;
    if (filt <= NEAR_V)     obs_next = 1'b1;
    else if (filt >= FAR_V) obs_next = 1'b0;
  end

  // Results are captured leaving POST so they are already stable while dist_valid is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dist_cm      <= '0;
      out_of_range <= 1'b0;
      obstacle     <= 1'b0;
    end else if (state_q == POST) begin
      dist_cm      <= filt;
      out_of_range <= (quo > MAX_RAW);
      obstacle     <= obs_next;
    end
  end

endmodule

// File: tb/tb_distance_converter.sv
// Randomized self-checking bench for distance_converter against an arithmetic reference model.
// Honours DIST_MEDIAN3_EN in its model so it runs against either build.
module tb_distance_converter;

  localparam int CPC  = 2900;
  localparam int MAXC = 400;
  localparam int NEAR = 15;
  localparam int FAR  = 20;
  localparam int LAT  = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        raw_valid;
  logic [21:0] raw_count;
  logic        busy;
  logic        dist_valid;
  logic [9:0]  dist_cm;
  logic        out_of_range;
  logic        obstacle;
  logic        overrun;

  int vectors     = 0;
  int miscompares = 0;

  int exp_cm;
  bit exp_oor;
  bit exp_obs;
  bit m_obs;
`ifdef DIST_MEDIAN3_EN
  int m_h1;
  int m_h2;
`endif

  distance_converter #(
    .CYCLES_PER_CM(CPC),
    .MAX_CM       (MAXC),
    .NEAR_CM      (NEAR),
    .FAR_CM       (FAR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .raw_valid    (raw_valid),
    .raw_count    (raw_count),
    .busy         (busy),
    .dist_valid   (dist_valid),
    .dist_cm      (dist_cm),
    .out_of_range (out_of_range),
    .obstacle     (obstacle),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_obs = 1'b0;
`ifdef DIST_MEDIAN3_EN
    m_h1 = MAXC;
    m_h2 = MAXC;
`endif
  endtask

  // Reference: floor divide, clamp, optional median of the last three, then hysteresis.
  task automatic model_step(input int raw);
    int q;
    int s;
    int f;
`ifdef DIST_MEDIAN3_EN
    int v[$];
`endif
    q       = raw / CPC;
    exp_oor = (q > MAXC);
    s       = (q > MAXC) ? MAXC : q;
`ifdef DIST_MEDIAN3_EN
    v = {s, m_h1, m_h2};
    v.sort();
    f    = v[1];
    m_h2 = m_h1;
    m_h1 = s;
`else
    f = s;
`endif
    if (f <= NEAR)     m_obs = 1'b1;
    else if (f >= FAR) m_obs = 1'b0;
    exp_cm  = f;
    exp_obs = m_obs;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic convert(input int raw, output int got_cm, output bit got_obs);
    int k;
    bit busy_ok;
    raw_valid = 1'b1;
    raw_count = 22'(raw);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_before_start: busy=%b want 0", busy);
    end
    model_step(raw);
    @(negedge clk);
    raw_valid = 1'b0;
    k = 1;
    busy_ok = 1'b1;
    while (dist_valid !== 1'b1 && k < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    vectors++;
    if (k != LAT) begin
      miscompares++;
      $display("FAIL latency raw=%0d: dist_valid in cycle %0d want %0d", raw, k, LAT);
    end
    vectors++;
    if (!busy_ok || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_during raw=%0d: busy dropped during conversion", raw);
    end
    vectors++;
    if (dist_cm !== 10'(exp_cm)) begin
      miscompares++;
      $display("FAIL dist_cm raw=%0d: got %0d want %0d", raw, dist_cm, exp_cm);
    end
    vectors++;
    if (out_of_range !== exp_oor) begin
      miscompares++;
      $display("FAIL out_of_range raw=%0d: got %b want %b", raw, out_of_range, exp_oor);
    end
    vectors++;
    if (obstacle !== exp_obs) begin
      miscompares++;
      $display("FAIL obstacle raw=%0d: got %b want %b", raw, obstacle, exp_obs);
    end
    got_cm  = int'(dist_cm);
    got_obs = obstacle;
    @(negedge clk);
    vectors++;
    if (dist_valid !== 1'b0 || busy !== 1'b0 || dist_cm !== 10'(exp_cm)
        || obstacle !== exp_obs || out_of_range !== exp_oor) begin
      miscompares++;
      $display("FAIL pulse_end raw=%0d: dist_valid=%b busy=%b dist_cm=%0d want 0 0 %0d (held)",
               raw, dist_valid, busy, dist_cm, exp_cm);
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({busy, dist_valid, dist_cm, out_of_range, obstacle, overrun} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b dv=%b cm=%0d oor=%b obs=%b ovr=%b want all 0",
               busy, dist_valid, dist_cm, out_of_range, obstacle, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_spot();
    int cm;
    bit obs;
    do_reset();
    convert(29000, cm, obs);
`ifndef DIST_MEDIAN3_EN
    vectors++;
    if (cm != 10 || obs !== 1'b1) begin
      miscompares++;
      $display("FAIL spot_29000: cm=%0d obs=%b want 10 1", cm, obs);
    end
`endif
    convert(2000000, cm, obs);
`ifndef DIST_MEDIAN3_EN
    vectors++;
    if (cm != 400 || obs !== 1'b0 || out_of_range !== 1'b1) begin
      miscompares++;
      $display("FAIL spot_2000000: cm=%0d obs=%b oor=%b want 400 0 1", cm, obs, out_of_range);
    end
`endif
    convert(0, cm, obs);
    convert(CPC - 1, cm, obs);
    convert(MAXC * CPC + CPC - 1, cm, obs);
    convert((MAXC + 1) * CPC, cm, obs);
    convert(22'h3FFFFF, cm, obs);
  endtask

  task automatic test_hysteresis();
    int seq_cm[4]  = '{10, 17, 25, 17};
    bit want_obs[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int cm;
    bit obs;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      convert(seq_cm[i] * CPC + int'($urandom_range(0, CPC - 1)), cm, obs);
`ifndef DIST_MEDIAN3_EN
      vectors++;
      if (obs !== want_obs[i]) begin
        miscompares++;
        $display("FAIL hysteresis step %0d: obstacle=%b want %b", i, obs, want_obs[i]);
      end
`endif
    end
  endtask

  task automatic test_median();
    int seq_cm[4]  = '{100, 100, 5, 100};
    int want_cm[4] = '{400, 100, 100, 100};
    int cm;
    bit obs;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      convert(seq_cm[i] * CPC, cm, obs);
`ifdef DIST_MEDIAN3_EN
      vectors++;
      if (cm != want_cm[i] || obs !== 1'b0) begin
        miscompares++;
        $display("FAIL median step %0d: cm=%0d obs=%b want %0d 0", i, cm, obs, want_cm[i]);
      end
`else
      if (cm < 0 && want_cm[i] < 0) $display("unreachable");
`endif
    end
  endtask

  task automatic test_overrun();
    int k;
    int pulses;
    int first;
    do_reset();
    first = int'($urandom_range(0, 60 * CPC));
    raw_valid = 1'b1;
    raw_count = 22'(first);
    model_step(first);
    @(negedge clk);
    raw_valid = 1'b0;
    k = 1;
    repeat (4) begin
      @(negedge clk);
      k++;
    end
    raw_valid = 1'b1;
    raw_count = 22'(first + 123 * CPC);
    #1;
    vectors++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_pulse: overrun=%b busy=%b want 1 1", overrun, busy);
    end
    @(negedge clk);
    raw_valid = 1'b0;
    k++;
    #1;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_clear: overrun=%b want 0", overrun);
    end
    while (dist_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (k != LAT || dist_cm !== 10'(exp_cm)) begin
      miscompares++;
      $display("FAIL overrun_result: cycle %0d cm=%0d want cycle %0d cm=%0d",
               k, dist_cm, LAT, exp_cm);
    end
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (dist_valid === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL overrun_extra: %0d extra dist_valid pulses want 0", pulses);
    end
  endtask

  task automatic test_reset_mid_div();
    int pulses;
    int cm;
    bit obs;
    do_reset();
    convert(12 * CPC, cm, obs);
    raw_valid = 1'b1;
    raw_count = 22'(8 * CPC);
    @(negedge clk);
    raw_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, dist_valid, dist_cm, out_of_range, obstacle, overrun} !== 15'd0) begin
      miscompares++;
      $display("FAIL mid_div_reset: busy=%b dv=%b cm=%0d oor=%b obs=%b ovr=%b want all 0",
               busy, dist_valid, dist_cm, out_of_range, obstacle, overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (dist_valid === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL mid_div_abort: %0d dist_valid pulses want 0", pulses);
    end
    convert(30 * CPC + 7, cm, obs);
  endtask

  task automatic test_random();
    int cm;
    bit obs;
    int raw;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       raw = int'($urandom_range(0, 30 * CPC));
        1:       raw = int'($urandom_range(0, (MAXC + 20) * CPC));
        2:       raw = int'($urandom & 32'h003F_FFFF);
        default: raw = int'($urandom_range(NEAR * CPC - 3, FAR * CPC + 3));
      endcase
      convert(raw, cm, obs);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int cm;
    bit obs;
    for (int i = 0; i < 10; i++) begin
      convert(int'($urandom_range(0, 25 * CPC)), cm, obs);
    end
  endtask

  initial begin
    rst       = 1'b1;
    raw_valid = 1'b0;
    raw_count = '0;
    model_reset();
    test_reset();
    test_spot();
    test_hysteresis();
    test_median();
    test_overrun();
    test_reset_mid_div();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/distance_converter.md
DISTANCE_CONVERTER -- requirements
Module: distance_converter

Interface
REQ-001 SHALL have parameter CYCLES_PER_CM, default 2900, meaning the echo clock cycles per centimetre at 50 MHz (58 us).
REQ-002 SHALL have parameter MAX_CM, default 400, meaning the saturation distance in cm.
REQ-003 SHALL have parameter NEAR_CM, default 15, meaning the obstacle-set threshold in cm.
REQ-004 SHALL have parameter FAR_CM, default 20, meaning the obstacle-clear threshold in cm; FAR_CM > NEAR_CM.
REQ-005 SHALL have port clk, input, 1 bit, the 50 MHz clock.
REQ-006 SHALL have port rst, input, 1 bit, the reset: asynchronous, active-high.
REQ-007 SHALL have port raw_valid, input, 1 bit, a one-cycle pulse marking a completed echo measurement.
REQ-008 SHALL have port raw_count, input, 22 bits, the echo width in clk cycles, sampled when raw_valid is high.
REQ-009 SHALL have port busy, output, 1 bit, high while a conversion is in progress.
REQ-010 SHALL have port dist_valid, output, 1 bit, a one-cycle pulse marking a new dist_cm.
REQ-011 SHALL have port dist_cm, output, 10 bits, the filtered distance in cm.
REQ-012 SHALL have port out_of_range, output, 1 bit, set when the latest unfiltered quotient exceeded MAX_CM.
REQ-013 SHALL have port obstacle, output, 1 bit, the hysteresis obstacle flag.
REQ-014 SHALL have port overrun, output, 1 bit, a one-cycle pulse when raw_valid arrives while busy.

Function
REQ-015 SHALL implement FSM states IDLE, DIV, POST, OUT; the reset state is IDLE.
REQ-016 IDLE: on raw_valid=1, SHALL latch raw_count and go to DIV; otherwise stay in IDLE.
REQ-017 DIV: SHALL perform a restoring unsigned divide raw_count / CYCLES_PER_CM, one quotient bit per cycle, exactly 22 cycles, then go to POST.
REQ-018 POST (1 cycle): SHALL saturate the quotient to MAX_CM, set out_of_range to (quotient > MAX_CM), apply the filter, then go to OUT.
REQ-019 OUT (1 cycle): SHALL assert dist_valid, update dist_cm and obstacle, then return to IDLE.
REQ-020 dist_valid SHALL be high exactly 24 cycles after the edge that accepted raw_valid.
REQ-021 busy SHALL be high in DIV, POST and OUT, and low in IDLE.
REQ-022 raw_valid while busy SHALL be ignored and SHALL pulse overrun in the same cycle; the conversion in progress is unaffected.
REQ-023 The quotient SHALL be truncated (floor); the remainder is discarded.
REQ-024 raw_count=0 SHALL yield dist_cm input 0, which is a legal distance.
REQ-025 obstacle SHALL set when filtered distance <= NEAR_CM and clear when filtered distance >= FAR_CM; between the thresholds it holds its value.
REQ-026 dist_cm, out_of_range and obstacle SHALL hold their values between dist_valid pulses.

Reset
REQ-027 On rst, SHALL clear state to IDLE and busy, dist_valid, overrun, out_of_range and obstacle to 0, and set dist_cm to 0.
REQ-028 rst asserted mid-DIV SHALL abort the conversion with no dist_valid; the first raw_valid after reset release SHALL start a fresh conversion.
REQ-029 On rst, the filter history SHALL be set to MAX_CM.

Configuration
REQ-030 With macro DIST_MEDIAN3_EN defined, POST SHALL output the median of {new, h1, h2}, then shift the history (h2<=h1, h1<=new).
REQ-031 Without DIST_MEDIAN3_EN, POST SHALL pass the saturated quotient straight through, and no history registers SHALL exist.

Structure
REQ-032 Package dist_pkg SHALL hold the FSM state enum, the CM_W=10 and RAW_W=22 width constants, and a saturation function.
REQ-033 The divider SHALL be a sub-module udiv_seq with start/done handshake, parameterised dividend and divisor widths; the top holds FSM, filter and hysteresis.

Verification
REQ-034 raw_count=29000 pulse -> dist_cm=10, obstacle=1, out_of_range=0, dist_valid exactly 24 cycles later.
REQ-035 raw_count=2000000 -> dist_cm=400, out_of_range=1, obstacle=0.
REQ-036 Hysteresis sequence 10,17,25,17 cm (no median) -> obstacle 1,1,0,0.
REQ-037 Median on, samples 100,100,5,100 cm -> dist_cm 400,100,100,100; spike rejected, obstacle stays 0.
REQ-038 raw_valid at cycle 5 of DIV -> overrun pulse, single dist_valid for the first sample; rst at cycle 10 of DIV -> no dist_valid, all outputs 0.
